// File: rtl/tp02_symbol_sender.sv
// rtl/tp02_symbol_sender.sv - TP02 frame transmitter: SYNC pulse then LOW/HIGH controle strobe per two-bit symbol.
// Optional trailing parity symbol enabled by TP02_TX_PARITY_EN.
module tp02_symbol_sender #(
    parameter int NSYM = 4,
    parameter int LENW = 3,
    parameter int HOLD = 1
) (
    input  logic              clk,
    input  logic              start,
    input  logic              load,
    input  logic [2*NSYM-1:0] data,
    input  logic [LENW-1:0]   len,
    output logic              ready,
    output logic              done,
    output logic              tx_start,
    output logic              tx_in1,
    output logic              tx_in2,
    output logic              tx_controle
);

    localparam int DW = 2*NSYM + 2;
    localparam int PW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [PW-1:0]   PH_LAST = PW'(HOLD - 1);
    localparam logic [PW-1:0]   PH_ONE  = PW'(1);
    localparam logic [LENW:0]   ONE     = (LENW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_LOW, S_HIGH} state_t;

    state_t          state, nxt;
    logic [PW-1:0]   phase_q, phase_n;
    logic [LENW:0]   idx_q, idx_n, tot_q, tot_n, tot_acc;
    logic [DW-1:0]   data_q, data_n, pack;
    logic [LENW-1:0] len_eff;
    logic            done_n;

    // Frame is packed so the symbol on the wire is always data_q[1:0];
    // symbols beyond the clamped length are masked off.
    always_comb begin
        len_eff = (int'(len) > NSYM) ? LENW'(NSYM) : len;
        pack    = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (i < int'(len_eff))
                pack[2*i +: 2] = data[2*i +: 2];
        end
`ifdef TP02_TX_PARITY_EN
        begin
            logic [1:0] par;
            par = 2'b00;
            for (int i = 0; i < NSYM; i++) begin
                if (i < int'(len_eff))
                    par = par ^ data[2*i +: 2];
            end
            for (int i = 0; i <= NSYM; i++) begin
                if (i == int'(len_eff))
                    pack[2*i +: 2] = par;
            end
        end
        tot_acc = {1'b0, len_eff} + ONE;
`else
        tot_acc = {1'b0, len_eff};
`endif
    end

    always_comb begin
        nxt     = state;
        phase_n = phase_q;
        idx_n   = idx_q;
        tot_n   = tot_q;
        data_n  = data_q;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    nxt     = S_SYNC;
                    data_n  = pack;
                    tot_n   = tot_acc;
                    idx_n   = '0;
                    phase_n = '0;
                end
            end
            S_SYNC: begin
                if (tot_q == '0) begin
                    nxt    = S_IDLE;
                    done_n = 1'b1;
                end else begin
                    nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_q == PH_LAST) begin
                    nxt     = S_HIGH;
                    phase_n = '0;
                end else begin
                    phase_n = phase_q + PH_ONE;
                end
            end
            S_HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_n = '0;
                    if (idx_q + ONE == tot_q) begin
                        nxt    = S_IDLE;
                        done_n = 1'b1;
                    end else begin
                        nxt    = S_LOW;
                        idx_n  = idx_q + ONE;
                        data_n = data_q >> 2;
                    end
                end else begin
                    phase_n = phase_q + PH_ONE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (start) begin
            state       <= S_IDLE;
            phase_q     <= '0;
            idx_q       <= '0;
            tot_q       <= '0;
            data_q      <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            tx_start    <= 1'b0;
            tx_in1      <= 1'b0;
            tx_in2      <= 1'b0;
            tx_controle <= 1'b1;
        end else begin
            state       <= nxt;
            phase_q     <= phase_n;
            idx_q       <= idx_n;
            tot_q       <= tot_n;
            data_q      <= data_n;
            ready       <= (nxt == S_IDLE);
            done        <= done_n;
            tx_start    <= (nxt == S_SYNC);
            tx_controle <= (nxt != S_LOW);
            if (nxt == S_LOW || nxt == S_HIGH) begin
                tx_in1 <= data_n[1];
                tx_in2 <= data_n[0];
            end else begin
                tx_in1 <= 1'b0;
                tx_in2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tp02_symbol_sender.sv
// tb/tb_tp02_symbol_sender.sv - directed vector bench for tp02_symbol_sender with a receiver model.
module tb_tp02_symbol_sender;

    logic       clk = 1'b0;
    logic       start, load, load2;
    logic [7:0] data, data2;
    logic [2:0] len, len2;
    logic       ready, done, tx_start, tx_in1, tx_in2, tx_controle;
    logic       ready2, done2, tx_start2, tx_in1_2, tx_in2_2, tx_controle2;

    always #5 clk = ~clk;

    tp02_symbol_sender #(.NSYM(4), .LENW(3), .HOLD(1)) dut (
        .clk(clk), .start(start), .load(load), .data(data), .len(len),
        .ready(ready), .done(done), .tx_start(tx_start), .tx_in1(tx_in1),
        .tx_in2(tx_in2), .tx_controle(tx_controle));

    tp02_symbol_sender #(.NSYM(4), .LENW(3), .HOLD(2)) dut2 (
        .clk(clk), .start(start), .load(load2), .data(data2), .len(len2),
        .ready(ready2), .done(done2), .tx_start(tx_start2), .tx_in1(tx_in1_2),
        .tx_in2(tx_in2_2), .tx_controle(tx_controle2));

    // {ready, done, tx_start, tx_in1, tx_in2, tx_controle}
    wire [5:0] obs1 = {ready, done, tx_start, tx_in1, tx_in2, tx_controle};
    wire [5:0] obs2 = {ready2, done2, tx_start2, tx_in1_2, tx_in2_2, tx_controle2};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       load;
        logic [2:0] len;
        logic [7:0] data;
        logic [5:0] exp;
    } vec_t;
    vec_t vq[$];

    function automatic void add(input logic l, input logic [2:0] n, input logic [7:0] d, input logic [5:0] e);
        vec_t v;
        v.load = l; v.len = n; v.data = d; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Receiver model: symbol captured on controle 0->1, frame closed on done.
    logic        prev_ctl = 1'b1;
    logic [15:0] rx_syms = '0;
    int          rx_n = 0;
    int          done_cnt = 0;
    logic [15:0] fr_syms[$];
    int          fr_n[$];

    always @(negedge clk) begin
        if (tx_start) begin
            rx_n    = 0;
            rx_syms = '0;
        end else if (!prev_ctl && tx_controle) begin
            rx_syms = {rx_syms[13:0], tx_in1, tx_in2};
            rx_n++;
        end
        if (done) begin
            done_cnt++;
            fr_syms.push_back(rx_syms);
            fr_n.push_back(rx_n);
        end
        prev_ctl = tx_controle;
    end

    logic [5:0] h2_exp[$];
    int         dc0;
    bit         found;

    initial begin
        start = 1'b1; load = 1'b0; data = '0; len = '0;
        load2 = 1'b0; data2 = '0; len2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs1, 6'b100001);
        chk("reset_h2", obs2, 6'b100001);
        start = 1'b0;

        // HOLD=1, len=2, sym0=01 sym1=10
        add(1, 3'd2, 8'h09, 6'b001001);
        add(0, 3'd0, 8'h00, 6'b000010);
        add(0, 3'd0, 8'h00, 6'b000011);
        add(0, 3'd0, 8'h00, 6'b000100);
        add(0, 3'd0, 8'h00, 6'b000101);
`ifdef TP02_TX_PARITY_EN
        add(0, 3'd0, 8'h00, 6'b000110);
        add(0, 3'd0, 8'h00, 6'b000111);
`endif
        add(0, 3'd0, 8'h00, 6'b110001);
        add(0, 3'd0, 8'h00, 6'b100001);
        // len=0 frame
        add(1, 3'd0, 8'hff, 6'b001001);
`ifdef TP02_TX_PARITY_EN
        add(0, 3'd0, 8'h00, 6'b000000);
        add(0, 3'd0, 8'h00, 6'b000001);
`endif
        add(0, 3'd0, 8'h00, 6'b110001);
        add(0, 3'd0, 8'h00, 6'b100001);
        // len=7 clamped to 4; stray loads mid-frame are ignored
        add(1, 3'd7, 8'hE4, 6'b001001);
        add(1, 3'd1, 8'hff, 6'b000000);
        add(0, 3'd0, 8'h00, 6'b000001);
        add(1, 3'd1, 8'hff, 6'b000010);
        add(0, 3'd0, 8'h00, 6'b000011);
        add(0, 3'd0, 8'h00, 6'b000100);
        add(1, 3'd1, 8'hff, 6'b000101);
        add(0, 3'd0, 8'h00, 6'b000110);
        add(1, 3'd1, 8'hff, 6'b000111);
`ifdef TP02_TX_PARITY_EN
        add(0, 3'd0, 8'h00, 6'b000000);
        add(0, 3'd0, 8'h00, 6'b000001);
`endif
        add(0, 3'd0, 8'h00, 6'b110001);
        add(0, 3'd0, 8'h00, 6'b100001);

        foreach (vq[i]) begin
            load = vq[i].load; len = vq[i].len; data = vq[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), obs1, vq[i].exp);
        end
        load = 1'b0;

        // HOLD=2, len=1, sym0=11
        h2_exp = '{6'b001001, 6'b000110, 6'b000110, 6'b000111, 6'b000111,
`ifdef TP02_TX_PARITY_EN
                   6'b000110, 6'b000110, 6'b000111, 6'b000111,
`endif
                   6'b110001, 6'b100001};
        load2 = 1'b1; len2 = 3'd1; data2 = 8'h03;
        foreach (h2_exp[i]) begin
            @(posedge clk);
            #1;
            load2 = 1'b0;
            chk($sformatf("hold2_c%0d", i + 1), obs2, h2_exp[i]);
        end

        // Abort mid-frame; start beats a simultaneous load
        dc0 = done_cnt;
        load = 1'b1; len = 3'd2; data = 8'h09;
        @(posedge clk); #1;
        load = 1'b0;
        chk("abort_sync", obs1, 6'b001001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; load = 1'b1; len = 3'd0;
        @(posedge clk); #1;
        chk("abort_reset", obs1, 6'b100001);
        start = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        chk("after_abort_sync", obs1, 6'b001001);
`ifdef TP02_TX_PARITY_EN
        @(posedge clk); #1;
        chk("after_abort_par_lo", obs1, 6'b000000);
        @(posedge clk); #1;
        chk("after_abort_par_hi", obs1, 6'b000001);
`endif
        @(posedge clk); #1;
        chk("after_abort_done", obs1, 6'b110001);
        @(negedge clk); #1;
        chk_int("abort_done_count", done_cnt - dc0, 1);

        // Back-to-back frames with load held high
        fr_syms.delete();
        fr_n.delete();
        load = 1'b1; len = 3'd1; data = 8'h02;
        @(posedge clk); #1;
        chk("b2b_sync1", obs1, 6'b001001);
        data = 8'h01;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        chk("b2b_done1", obs1, 6'b110001);
        @(posedge clk); #1;
        load = 1'b0;
        chk("b2b_sync2", obs1, 6'b001001);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        chk("b2b_done2", obs1, 6'b110001);
        @(negedge clk); #1;
        chk_int("rx_frames", fr_n.size(), 2);
        if (fr_n.size() >= 2) begin
`ifdef TP02_TX_PARITY_EN
            chk_int("rx_f1_n", fr_n[0], 2);
            chk_int("rx_f1_syms", int'(fr_syms[0]), 16'h000A);
            chk_int("rx_f2_n", fr_n[1], 2);
            chk_int("rx_f2_syms", int'(fr_syms[1]), 16'h0005);
`else
            chk_int("rx_f1_n", fr_n[0], 1);
            chk_int("rx_f1_syms", int'(fr_syms[0]), 16'h0002);
            chk_int("rx_f2_n", fr_n[1], 1);
            chk_int("rx_f2_syms", int'(fr_syms[1]), 16'h0001);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
